bmult6x6_cmp_sched: RTL

- Shares one `Bmult6x6_bitheap_cmp` bit-heap compressor among N_REQ requesters.
- Each requester submits a packed 28-bit partial-product heap over a valid/ready handshake.
- The scheduler arbitrates round-robin, registers the selected heap onto the compressor inputs, and tracks requester tags through the compressor latency.
- Each 13-bit result goes into a per-requester response FIFO, drained over a valid/ready handshake; credit-based flow control means no result is ever dropped.

---
 rtl/bmult6x6_cmp_sched.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bmult6x6_cmp_sched.sv
// bmult6x6_cmp_sched: round-robin scheduler sharing one bit-heap compressor among N_REQ requesters
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   req_valid/req_ready       per-requester request handshake; req_heap carries packed heaps
//   cmp_heap / cmp_out        registered heap to the compressor and its result back
//   rsp_valid/rsp_ready       per-requester response FIFO handshake; rsp_data is each FIFO head
//   busy                      tags in flight or results waiting
// Optional: define BMULT_SCHED_PERF_CNT_EN to add perf_issue, perf_stall and perf_cred_block counters.
module bmult6x6_cmp_sched #(
   parameter int N_REQ     = 4,
   parameter int CMP_LAT   = 1,
   parameter int RSP_DEPTH = 2,
   parameter int HEAP_W    = 28,
   parameter int OUT_W     = 13
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*HEAP_W-1:0] req_heap,
   output logic [HEAP_W-1:0]       cmp_heap,
   input  logic [OUT_W-1:0]        cmp_out,
   output logic [N_REQ-1:0]        rsp_valid,
   input  logic [N_REQ-1:0]        rsp_ready,
   output logic [N_REQ*OUT_W-1:0]  rsp_data,
   output logic                    busy
`ifdef BMULT_SCHED_PERF_CNT_EN
   ,
   output logic [31:0]             perf_issue,
   output logic [31:0]             perf_stall,
   output logic [31:0]             perf_cred_block
`endif
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(RSP_DEPTH + 1);
   logic [IW-1:0] ptr_q, ptr_d, gnt, idx;
   logic found;
   logic [N_REQ-1:0] elig, pop, push, xfer;
   logic [CW-1:0] cred_q [N_REQ];
   logic [CW-1:0] cred_d [N_REQ];
   logic [CW-1:0] cnt_q [N_REQ];
   logic [CW-1:0] cnt_d [N_REQ];
   logic [CW-1:0] widx;
   logic [OUT_W-1:0] fifo_q [N_REQ][RSP_DEPTH];
   logic [OUT_W-1:0] fifo_d [N_REQ][RSP_DEPTH];
   logic [HEAP_W-1:0] heap_q, heap_d;
   logic [CMP_LAT-1:0] tag_v_q;
   logic [IW-1:0] tag_id_q [CMP_LAT];
   // first eligible requester at or after ptr wins; reset masks every grant
   always_comb begin
      elig = '0;
      for (int i = 0; i < N_REQ; i++) elig[i] = req_valid[i] && cred_q[i] != '0 && !rst;
      found = 1'b0;
      gnt = '0;
      idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = IW'((int'(ptr_q) + k) % N_REQ);
         if (!found && elig[idx]) begin
            found = 1'b1;
            gnt = idx;
         end
      end
   end
   // FIFOs shift toward slot 0 so the head is always a register and vacated slots read as zero
   always_comb begin
      ptr_d = !found ? ptr_q : (gnt == IW'(N_REQ - 1)) ? '0 : gnt + IW'(1);
      heap_d = found ? req_heap[int'(gnt)*HEAP_W +: HEAP_W] : '0;
      widx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         xfer[i] = found && gnt == IW'(i);
         pop[i] = rsp_ready[i] && cnt_q[i] != '0;
         push[i] = tag_v_q[CMP_LAT-1] && tag_id_q[CMP_LAT-1] == IW'(i);
         cred_d[i] = cred_q[i] + CW'(pop[i]) - CW'(xfer[i]);
         cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
         widx = pop[i] ? cnt_q[i] - CW'(1) : cnt_q[i];
         for (int j = 0; j < RSP_DEPTH - 1; j++) fifo_d[i][j] = pop[i] ? fifo_q[i][j+1] : fifo_q[i][j];
         fifo_d[i][RSP_DEPTH-1] = pop[i] ? '0 : fifo_q[i][RSP_DEPTH-1];
         for (int j = 0; j < RSP_DEPTH; j++) if (push[i] && widx == CW'(j)) fifo_d[i][j] = cmp_out;
      end
   end
   always_comb begin
      rsp_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         rsp_valid[i] = cnt_q[i] != '0;
         rsp_data[i*OUT_W +: OUT_W] = fifo_q[i][0];
      end
   end
   assign req_ready = xfer;
   assign cmp_heap = heap_q;
   assign busy = |tag_v_q || |rsp_valid;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
         heap_q <= '0;
         tag_v_q <= '0;
         for (int s = 0; s < CMP_LAT; s++) tag_id_q[s] <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            cred_q[i] <= CW'(RSP_DEPTH);
            cnt_q[i] <= '0;
            for (int j = 0; j < RSP_DEPTH; j++) fifo_q[i][j] <= '0;
         end
      end else begin
         ptr_q <= ptr_d;
         heap_q <= heap_d;
         tag_v_q[0] <= found;
         tag_id_q[0] <= gnt;
         for (int s = 1; s < CMP_LAT; s++) begin
            tag_v_q[s] <= tag_v_q[s-1];
            tag_id_q[s] <= tag_id_q[s-1];
         end
         cred_q <= cred_d;
         cnt_q <= cnt_d;
         fifo_q <= fifo_d;
      end
   end
   for (genvar i = 0; i < N_REQ; i++) begin : g_chk
      a_cred: assert property (@(posedge clk) disable iff (rst)
         !(cred_q[i] > CW'(RSP_DEPTH)) && !(xfer[i] && cred_q[i] == '0));
   end
`ifdef BMULT_SCHED_PERF_CNT_EN
   logic [31:0] issue_q, stall_q, blk_q;
   logic blk;
   always_comb begin
      blk = 1'b0;
      for (int i = 0; i < N_REQ; i++) blk = blk | (req_valid[i] && cred_q[i] == '0);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_q <= '0;
         stall_q <= '0;
         blk_q <= '0;
      end else begin
         if (found && !(&issue_q)) issue_q <= issue_q + 32'd1;
         if (|req_valid && !found && !(&stall_q)) stall_q <= stall_q + 32'd1;
         if (blk && !(&blk_q)) blk_q <= blk_q + 32'd1;
      end
   end
   assign perf_issue = issue_q;
   assign perf_stall = stall_q;
   assign perf_cred_block = blk_q;
`endif
endmodule
